// File: rtl/aui_checker.sv
// AUI lane checker: compares every received lane against lane 0, tracks lane lock
// with count-based hysteresis, forwards the recovered word and keeps per-lane error counters.
module aui_checker #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUMBER_LANES  = 16,
  parameter int LOCK_COUNT    = 8,
  parameter int UNLOCK_COUNT  = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUMBER_LANES-1:0][DATA_WIDTH-1:0]      rx_lane,
  input  logic                                         i_valid,
  input  logic                                         i_clr_cnt,
  output logic [DATA_WIDTH-1:0]                        o_data,
  output logic                                         o_valid,
  output logic                                         o_locked,
  output logic [NUMBER_LANES-1:0]                      o_lane_err,
  output logic [NUMBER_LANES-1:0][ERR_CNT_WIDTH-1:0]   o_err_cnt
);

  localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int RUN_W   = $clog2(RUN_MAX) + 1;
  localparam logic [RUN_W-1:0] LOCK_TGT   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] UNLOCK_TGT = RUN_W'(UNLOCK_COUNT);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t                    state;
  logic [RUN_W-1:0]          run;
  logic [RUN_W-1:0]          run_inc;
  logic [NUMBER_LANES-1:0]   mis_p0;
  logic                      all_match_p0;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + ERR_CNT_WIDTH'(1);
  endfunction

  // Stage p0: lane comparison against the reference lane
  always_comb begin
    mis_p0 = '0;
    for (int i = 1; i < NUMBER_LANES; i++) begin
      mis_p0[i] = (rx_lane[i] != rx_lane[0]);
    end
  end

  assign all_match_p0 = ~|mis_p0;
  assign run_inc      = run + RUN_W'(1);
  assign o_locked     = (state == LOCKED);

  // Stage p1: lock hysteresis; o_valid reflects the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNLOCKED;
      run     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_valid) begin
        case (state)
          UNLOCKED: begin
            if (all_match_p0) begin
              if (run_inc == LOCK_TGT) begin
                state   <= LOCKED;
                run     <= '0;
                o_valid <= 1'b1;
              end else begin
                run <= run_inc;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (!all_match_p0) begin
              if (run_inc == UNLOCK_TGT) begin
                state <= UNLOCKED;
                run   <= '0;
              end else begin
                run     <= run_inc;
                o_valid <= 1'b1;
              end
            end else begin
              run     <= '0;
              o_valid <= 1'b1;
            end
          end
          default: begin
            state <= UNLOCKED;
            run   <= '0;
          end
        endcase
      end
    end
  end

  // Stage p1: recovered word, per-lane flags and saturating error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data     <= '0;
      o_lane_err <= '0;
      o_err_cnt  <= '0;
    end else begin
      o_lane_err <= i_valid ? mis_p0 : '0;
      if (i_valid) begin
        o_data <= rx_lane[0];
      end
      for (int i = 0; i < NUMBER_LANES; i++) begin
        if (i_clr_cnt) begin
          o_err_cnt[i] <= '0;
        end else if (i_valid && mis_p0[i]) begin
          o_err_cnt[i] <= sat_inc(o_err_cnt[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_aui_checker.sv
// Scoreboard bench for aui_checker: stimulus pushes expected outputs, a monitor pops and compares.
module tb_aui_checker;

  localparam int DW = 64;
  localparam int NL = 16;
  localparam int LC = 8;
  localparam int UC = 4;
  localparam int EW = 4;
  localparam logic [DW-1:0] W0 = 64'hA5A5_0000_0000_0001;

  typedef logic [NL-1:0][DW-1:0] lanes_t;
  typedef struct packed {
    logic                  v;
    logic                  l;
    logic [DW-1:0]         d;
    logic [NL-1:0]         le;
    logic [NL-1:0][EW-1:0] ec;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  lanes_t                rx_lane;
  logic                  i_valid;
  logic                  i_clr_cnt;
  logic [DW-1:0]         o_data;
  logic                  o_valid;
  logic                  o_locked;
  logic [NL-1:0]         o_lane_err;
  logic [NL-1:0][EW-1:0] o_err_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  bit            m_locked;
  int            m_run;
  logic [DW-1:0] m_data;
  int            m_cnt[NL];

  always #5 clk = ~clk;

  aui_checker #(
    .DATA_WIDTH   (DW),
    .NUMBER_LANES (NL),
    .LOCK_COUNT   (LC),
    .UNLOCK_COUNT (UC),
    .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_lane   (rx_lane),
    .i_valid   (i_valid),
    .i_clr_cnt (i_clr_cnt),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_locked  (o_locked),
    .o_lane_err(o_lane_err),
    .o_err_cnt (o_err_cnt)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic lanes_t mk(input logic [DW-1:0] w);
    lanes_t l;
    for (int i = 0; i < NL; i++) l[i] = w;
    return l;
  endfunction

  function automatic lanes_t corrupt(input logic [DW-1:0] w, input int lane);
    lanes_t l;
    l = mk(w);
    l[lane] = w ^ 64'h0000_0000_0000_00FF;
    return l;
  endfunction

  function automatic lanes_t garbage();
    lanes_t l;
    for (int i = 0; i < NL; i++) l[i] = {$urandom, $urandom};
    return l;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_run    = 0;
    m_data   = '0;
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
  endtask

  // Drive one cycle and push what the outputs must show after the next rising edge
  task automatic cyc(input logic v, input lanes_t ln, input logic clr);
    exp_t          e;
    logic [NL-1:0] mis;
    bit            am;
    @(negedge clk);
    rx_lane   = ln;
    i_valid   = v;
    i_clr_cnt = clr;
    mis = '0;
    for (int i = 1; i < NL; i++) mis[i] = (ln[i] != ln[0]);
    am = (mis == '0);
    for (int i = 0; i < NL; i++) begin
      if (clr) m_cnt[i] = 0;
      else if (v && mis[i] && m_cnt[i] < (2**EW - 1)) m_cnt[i]++;
    end
    if (v) begin
      m_data = ln[0];
      if (!m_locked) begin
        if (am) begin
          m_run++;
          if (m_run == LC) begin m_locked = 1'b1; m_run = 0; end
        end else m_run = 0;
      end else begin
        if (!am) begin
          m_run++;
          if (m_run == UC) begin m_locked = 1'b0; m_run = 0; end
        end else m_run = 0;
      end
    end
    e.v  = v && m_locked;
    e.l  = m_locked;
    e.d  = m_data;
    e.le = v ? mis : '0;
    for (int i = 0; i < NL; i++) e.ec[i] = EW'(m_cnt[i]);
    q.push_back(e);
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_valid"},  64'(o_valid),    64'd0);
    check({nm, "_locked"}, 64'(o_locked),   64'd0);
    check({nm, "_data"},   o_data,          64'd0);
    check({nm, "_lerr"},   64'(o_lane_err), 64'd0);
    check({nm, "_ecnt"},   o_err_cnt,       64'd0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("o_valid",    64'(o_valid),    64'(e.v));
      check("o_locked",   64'(o_locked),   64'(e.l));
      check("o_data",     o_data,          e.d);
      check("o_lane_err", 64'(o_lane_err), 64'(e.le));
      check("o_err_cnt",  o_err_cnt,       e.ec);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_clr_cnt = 1'b0;
    rx_lane   = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire lock on 8 matching words
    for (int n = 0; n < 8; n++) begin
      cyc(1'b1, mk(W0 + 64'(n)), 1'b0);
      if (n == 6) begin peek(); check("lock_after7", 64'(o_locked), 64'd0); end
    end
    peek();
    check("lock_after8", 64'(o_locked), 64'd1);
    check("valid_8th",   64'(o_valid),  64'd1);
    check("data_8th",    o_data,        W0 + 64'd7);

    // Three mismatches on lane 5 do not drop lock
    for (int k = 0; k < 3; k++) cyc(1'b1, corrupt(W0 + 64'(8 + k), 5), 1'b0);
    cyc(1'b1, mk(W0 + 64'd11), 1'b0);
    peek();
    check("l5_locked", 64'(o_locked),     64'd1);
    check("l5_cnt",    64'(o_err_cnt[5]), 64'd3);

    // Four mismatches on lane 15 drop lock
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, corrupt(W0 + 64'(12 + k), 15), 1'b0);
      if (k == 2) begin peek(); check("l15_still_locked", 64'(o_locked), 64'd1); end
    end
    peek();
    check("l15_unlocked", 64'(o_locked),      64'd0);
    check("l15_valid",    64'(o_valid),       64'd0);
    check("l15_cnt",      64'(o_err_cnt[15]), 64'd4);

    // 7 matches, lane-3 glitch, then 8 matches with an invalid garbage cycle inside
    w = 64'h1234_5678_0000_0000;
    for (int n = 0; n < 7; n++) begin
      cyc(1'b1, mk(w + 64'(n)), 1'b0);
      if (n == 2) cyc(1'b0, garbage(), 1'b0);
    end
    cyc(1'b1, corrupt(w + 64'd7, 3), 1'b0);
    for (int n = 0; n < 8; n++) begin
      cyc(1'b1, mk(w + 64'(8 + n)), 1'b0);
      if (n == 3) cyc(1'b0, garbage(), 1'b0);
      if (n == 6) begin peek(); check("relock_after7", 64'(o_locked), 64'd0); end
    end
    peek();
    check("relock_after8", 64'(o_locked),     64'd1);
    check("l3_cnt",        64'(o_err_cnt[3]), 64'd1);

    // Saturation, clear priority, count after clear
    for (int k = 0; k < 20; k++) cyc(1'b1, corrupt(w + 64'(k), 2), 1'b0);
    peek();
    check("l2_sat", 64'(o_err_cnt[2]), 64'hF);
    cyc(1'b1, corrupt(w, 2), 1'b1);
    peek();
    check("l2_clr", 64'(o_err_cnt[2]), 64'd0);
    cyc(1'b1, corrupt(w, 2), 1'b0);
    peek();
    check("l2_after_clr", 64'(o_err_cnt[2]), 64'd1);

    // Lock, then reset mid-lock and relock from scratch
    for (int n = 0; n < 8; n++) cyc(1'b1, mk(W0 + 64'(n)), 1'b0);
    peek();
    check("prerst_locked", 64'(o_locked), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    q.delete();
    @(negedge clk);
    i_valid   = 1'b0;
    i_clr_cnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cyc(1'b1, mk(W0 + 64'(32 + n)), 1'b0);
      if (n == 6) begin peek(); check("postrst_after7", 64'(o_locked), 64'd0); end
    end
    peek();
    check("postrst_after8", 64'(o_locked), 64'd1);
    check("postrst_data",   o_data,        W0 + 64'd39);

    cyc(1'b0, garbage(), 1'b0);
    cyc(1'b0, garbage(), 1'b0);
    @(posedge clk);
    #3;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aui_checker.md
# aui_checker

Receive-side counterpart of the AUI lane generator. Accepts NUMBER_LANES parallel lanes that carry the same broadcast word and compares every lane against lane 0. It acquires and loses lane lock with a two-state hysteresis machine, forwards the recovered word while locked, and keeps saturating per-lane mismatch counters for link diagnostics. It sits at the far end of the AUI lane bundle, ahead of the PCS/consumer logic.

## Interface
- DATA_WIDTH, 64, width of each lane word
- NUMBER_LANES, 16, number of lanes; lane 0 is the reference lane
- LOCK_COUNT, 8, consecutive all-match valid cycles needed to lock (≥1)
- UNLOCK_COUNT, 4, consecutive mismatch valid cycles needed to drop lock (≥1)
- ERR_CNT_WIDTH, 16, width of each per-lane error counter

- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rx_lane  input  [DATA_WIDTH-1:0] x NUMBER_LANES  received lane words
- i_valid  input  1  rx_lane contents are valid this cycle
- i_clr_cnt  input  1  synchronous clear of all error counters
- o_data  output  DATA_WIDTH  recovered word (registered rx_lane[0])
- o_valid  output  1  o_data valid and link locked
- o_locked  output  1  lock state register
- o_lane_err  output  NUMBER_LANES  per-lane mismatch flag, registered
- o_err_cnt  output  [ERR_CNT_WIDTH-1:0] x NUMBER_LANES  per-lane saturating mismatch counters

## Operation
- Per cycle, combinational: mis[i] = (rx_lane[i] != rx_lane[0]); mis[0] is always 0. all_match = ~|mis.
- Only cycles with i_valid=1 are evaluated. Cycles with i_valid=0 hold the state, run counters and error counters unchanged.
- FSM states: UNLOCKED (reset), LOCKED. One run counter, width clog2(max(LOCK_COUNT,UNLOCK_COUNT))+1.
- UNLOCKED: a valid all_match cycle increments run; when run+1 == LOCK_COUNT, go to LOCKED and clear run. A valid mismatch cycle clears run.
- LOCKED: a valid mismatch cycle increments run; when run+1 == UNLOCK_COUNT, go to UNLOCKED and clear run. A valid all_match cycle clears run.
- o_data <= rx_lane[0] whenever i_valid=1; it holds otherwise.
- o_valid <= i_valid & (next_state == LOCKED). The lock-acquiring cycle is therefore forwarded, and the lock-losing cycle is not. While locked, words are forwarded even on isolated mismatch cycles.
- o_lane_err[i] <= i_valid & mis[i].
- o_err_cnt[i]: i_clr_cnt=1 forces 0 and takes priority over a simultaneous mismatch. Otherwise it increments on i_valid & mis[i] and saturates at all-ones with no wrap. o_err_cnt[0] stays 0.
- o_locked = state register (1 when LOCKED).

## Timing
- Reset (async assert, sync-deasserted upstream): state UNLOCKED, run 0, o_data 0, o_valid 0, o_locked 0, o_lane_err 0, all o_err_cnt 0.
- Latency: 1 cycle from rx_lane/i_valid to o_data, o_valid, o_lane_err and o_err_cnt.
- o_locked rises on the edge that samples the LOCK_COUNT-th consecutive valid all_match cycle. It falls on the edge that samples the UNLOCK_COUNT-th consecutive valid mismatch cycle.
- Invalid cycles between valid cycles do not break consecutiveness.
- No back-pressure. Input is accepted every cycle.
- Reset asserted mid-operation clears everything immediately. Lock must be re-acquired from run=0.
- LOCK_COUNT=1 means lock is acquired on the first valid all_match cycle. UNLOCK_COUNT=1 means the first valid mismatch drops lock.

## Test plan
- Reset, then 8 valid cycles with all lanes = 64'hA5A5_0000_0000_0001 + n: o_locked rises after the 8th sampled edge. o_valid=1 on the 8th output cycle with o_data = 8th word. All o_err_cnt stay 0.
- While locked, corrupt lane 5 for 3 consecutive valid cycles, then match: o_locked stays 1, o_valid stays 1, o_lane_err[5]=1 for 3 cycles, o_err_cnt[5]=3.
- While locked, corrupt lane 15 for 4 consecutive valid cycles: o_locked falls on the 4th edge, o_valid=0 for that word, o_err_cnt[15]=4.
- Unlocked: 7 matching cycles, 1 cycle with lane 3 flipped, then 8 matching cycles: lock is asserted only after the last 8. An interleaved i_valid=0 cycle with garbage lanes does not reset run or count errors.
- ERR_CNT_WIDTH=4: mismatch on lane 2 for 20 valid cycles gives o_err_cnt[2]=4'hF. i_clr_cnt asserted together with a mismatch gives 0, and the next mismatch gives 1.
- Assert rst_n low mid-lock for 1 cycle: all outputs are 0 immediately, and 8 matching valid cycles are required to relock.
